// File: rtl/cpu_term_sm.sv
// cpu_term_sm: 68030-style bus-cycle sequencer for SDMAC DMA master bursts (STERM, DSACK sizing, BERR).
// Latency: AS one cycle after REQ is sampled; BEAT_ACK 1 cycle after STERM, 2 cycles after DSACK.
// Backpressure: REQ is taken only in IDLE; bus wait states hold WAIT. `CPU_SM_TIMEOUT_EN adds a watchdog.
module cpu_term_sm #(
    parameter  int BURST_MAX = 4,
    parameter  int TO_LIMIT  = 255,
    parameter  int TO_WIDTH  = 8,
    localparam int BW        = $clog2(BURST_MAX) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ,
    input  logic [BW-1:0] BEATS,
    input  logic [1:0]    nDSACK,
    input  logic          nSTERM,
    input  logic          nBERR,
    output logic          BUSY,
    output logic          AS,
    output logic          DS,
    output logic          BEAT_ACK,
    output logic          DONE,
    output logic          ERR,
    output logic          TOUT,
    output logic [1:0]    PORT_SZ,
    output logic [1:0]    SUB_IDX,
    output logic [BW-1:0] BEAT_IDX
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LATCH,
        S_TERM,
        S_ERR
    } state_t;

    state_t        state_q, state_nxt;
    logic [BW-1:0] beats_q, beats_nxt;
    logic [BW-1:0] beat_idx_q, beat_idx_nxt;
    logic [1:0]    sub_idx_q, sub_idx_nxt;
    logic [1:0]    port_sz_q, port_sz_nxt;
    logic          cmpl_q, cmpl_nxt;
    logic          busy_q, as_q, ds_q, beat_ack_q, done_q, err_q;
    logic [2:0]    sub_inc, sub_sum;
    logic          last_beat;
    logic          to_hit;
    logic          beat_ack_nxt;

    // Byte advance per termination: 32-bit port moves 4, 16-bit 2, 8-bit 1.
    always_comb begin
        case (port_sz_q)
            2'd0:    sub_inc = 3'd4;
            2'd1:    sub_inc = 3'd2;
            default: sub_inc = 3'd1;
        endcase
        sub_sum   = {1'b0, sub_idx_q} + sub_inc;
        last_beat = (beat_idx_q + BW'(1)) == beats_q;
    end

    always_comb begin
        state_nxt    = state_q;
        beats_nxt    = beats_q;
        beat_idx_nxt = beat_idx_q;
        sub_idx_nxt  = sub_idx_q;
        port_sz_nxt  = port_sz_q;
        cmpl_nxt     = cmpl_q;
        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    state_nxt    = S_ADDR;
                    beat_idx_nxt = '0;
                    sub_idx_nxt  = '0;
                    if (BEATS == '0)
                        beats_nxt = BW'(1);
                    else if (BEATS > BW'(BURST_MAX))
                        beats_nxt = BW'(BURST_MAX);
                    else
                        beats_nxt = BEATS;
                end
            end
            S_ADDR: state_nxt = S_WAIT;
            S_WAIT: begin
                if (!nBERR) begin
                    state_nxt = S_ERR;
                end else if (!nSTERM) begin
                    state_nxt   = S_TERM;
                    port_sz_nxt = 2'd0;
                    cmpl_nxt    = 1'b1;
                end else if (nDSACK != 2'b11) begin
                    state_nxt   = S_LATCH;
                    port_sz_nxt = (nDSACK == 2'b00) ? 2'd0 :
                                  (nDSACK == 2'b01) ? 2'd1 : 2'd2;
                end else if (to_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_LATCH: begin
                if (!nBERR) begin
                    state_nxt = S_ERR;
                end else begin
                    state_nxt = S_TERM;
                    cmpl_nxt  = sub_sum[2];
                end
            end
            S_TERM: begin
                // Completeness was resolved on entry so BEAT_ACK/DONE can be registered.
                if (cmpl_q) begin
                    sub_idx_nxt = '0;
                    if (last_beat) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt    = S_ADDR;
                        beat_idx_nxt = beat_idx_q + BW'(1);
                    end
                end else begin
                    state_nxt   = S_ADDR;
                    sub_idx_nxt = sub_sum[1:0];
                end
            end
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        beat_ack_nxt = (state_nxt == S_TERM) && cmpl_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            beats_q    <= '0;
            beat_idx_q <= '0;
            sub_idx_q  <= '0;
            port_sz_q  <= '0;
            cmpl_q     <= 1'b0;
            busy_q     <= 1'b0;
            as_q       <= 1'b0;
            ds_q       <= 1'b0;
            beat_ack_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            beats_q    <= beats_nxt;
            beat_idx_q <= beat_idx_nxt;
            sub_idx_q  <= sub_idx_nxt;
            port_sz_q  <= port_sz_nxt;
            cmpl_q     <= cmpl_nxt;
            busy_q     <= state_nxt != S_IDLE;
            as_q       <= state_nxt inside {S_ADDR, S_WAIT, S_LATCH};
            ds_q       <= state_nxt inside {S_WAIT, S_LATCH};
            beat_ack_q <= beat_ack_nxt;
            done_q     <= beat_ack_nxt && last_beat;
            err_q      <= state_nxt == S_ERR;
        end
    end

`ifdef CPU_SM_TIMEOUT_EN
    logic [TO_WIDTH-1:0] to_cnt_q;
    logic                tout_q;

    // Counter value equals completed WAIT cycles; a termination at the limit wins by priority.
    assign to_hit = to_cnt_q == TO_WIDTH'(TO_LIMIT - 1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt_q <= '0;
            tout_q   <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == S_WAIT && state_nxt == S_WAIT) ? to_cnt_q + TO_WIDTH'(1) : '0;
            if (state_q == S_IDLE && REQ)
                tout_q <= 1'b0;
            else if (state_q == S_WAIT && state_nxt == S_ERR && nBERR)
                tout_q <= 1'b1;
        end
    end

    assign TOUT = tout_q;
`else
    assign to_hit = 1'b0;
    assign TOUT   = 1'b0;
`endif

    assign BUSY     = busy_q;
    assign AS       = as_q;
    assign DS       = ds_q;
    assign BEAT_ACK = beat_ack_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign PORT_SZ  = port_sz_q;
    assign SUB_IDX  = sub_idx_q;
    assign BEAT_IDX = beat_idx_q;

endmodule
